// File: rtl/sine_cos_arbiter.sv
// Round-robin front end that shares one pipelined sine/cosine calculator between
// NUM_REQ requesters and routes each returned result back as a one-cycle pulse.
module sine_cos_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int CALC_LATENCY = 2,
  parameter int CNT_W        = 16,
  localparam int W           = EXP_LEN + MANTISSA_LEN + 1,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_theta,
  input  logic [NUM_REQ-1:0]   req_sine_cosine,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [W-1:0]         resp_value,
  output logic                 calc_enable,
  output logic [W-1:0]         calc_theta,
  output logic                 calc_sine_cosine,
  input  logic [W-1:0]         calc_value,
  output logic                 idle,
  output logic [CNT_W-1:0]     issue_count
);

  logic [IDX_W-1:0]        last_q, last_d;
  logic [CALC_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]        tag_idx_q [CALC_LATENCY];
  logic [CNT_W-1:0]        issue_count_q, issue_count_d;

  logic                    grant_vld;
  logic [IDX_W-1:0]        grant_idx;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Walk the search order backwards so the nearest valid requester after last_q is
  // the final one written; rst_n gating keeps every combinational output quiet in reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (rst_n && !halt) begin
      for (int off = NUM_REQ; off >= 1; off--) begin
        if (req_valid[wrap_idx(int'(last_q) + off)]) begin
          grant_vld = 1'b1;
          grant_idx = wrap_idx(int'(last_q) + off);
        end
      end
    end
  end

  always_comb begin
    req_ready        = '0;
    calc_enable      = grant_vld;
    calc_theta       = '0;
    calc_sine_cosine = 1'b0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      calc_theta           = req_theta[int'(grant_idx)*W +: W];
      calc_sine_cosine     = req_sine_cosine[grant_idx];
    end
  end

  always_comb begin
    last_d        = grant_vld ? grant_idx : last_q;
    tag_vld_d     = CALC_LATENCY'({tag_vld_q, grant_vld});
    issue_count_d = issue_count_q + CNT_W'(grant_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= IDX_W'(NUM_REQ - 1);
      tag_vld_q     <= '0;
      issue_count_q <= '0;
    end else begin
      last_q        <= last_d;
      tag_vld_q     <= tag_vld_d;
      issue_count_q <= issue_count_d;
    end
  end

  // Tag indices need no reset: they only matter while the matching valid bit is set.
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= grant_idx;
    for (int s = 1; s < CALC_LATENCY; s++) begin
      tag_idx_q[s] <= tag_idx_q[s-1];
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_value = '0;
    if (tag_vld_q[CALC_LATENCY-1]) begin
      resp_valid[tag_idx_q[CALC_LATENCY-1]] = 1'b1;
      resp_value                            = calc_value;
    end
  end

  assign idle        = ~(|tag_vld_q) & ~grant_vld;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_sine_cos_arbiter.sv
// Directed, table-driven bench for sine_cos_arbiter with a two-stage calculator model.
module tb_sine_cos_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           halt;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_theta;
  logic [N-1:0]   req_sine_cosine;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_value;
  logic           calc_enable;
  logic [W-1:0]   calc_theta;
  logic           calc_sine_cosine;
  logic [W-1:0]   calc_value;
  logic           idle;
  logic [CW-1:0]  issue_count;

  sine_cos_arbiter #(
    .NUM_REQ(N), .EXP_LEN(8), .MANTISSA_LEN(23), .CALC_LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .req_valid(req_valid), .req_theta(req_theta), .req_sine_cosine(req_sine_cosine),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_value(resp_value),
    .calc_enable(calc_enable), .calc_theta(calc_theta), .calc_sine_cosine(calc_sine_cosine),
    .calc_value(calc_value), .idle(idle), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] calc_f(input logic [W-1:0] th, input logic sc);
    return th ^ (sc ? 32'h0000_FFFF : 32'hA5A5_0000);
  endfunction

  // Calculator model: result of an issue in cycle t is presented during cycle t+2.
  logic [W-1:0] cpipe0, cpipe1;
  always @(posedge clk) begin
    cpipe0 <= calc_f(calc_theta, calc_sine_cosine);
    cpipe1 <= cpipe0;
  end
  assign calc_value = cpipe1;

  logic [W-1:0] th [N];
  logic [N-1:0] sc_v;
  int           n_vec  = 0;
  int           n_fail = 0;
  logic [CW-1:0] exp_cnt;

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic         h;
    logic [N-1:0] er;
    logic [N-1:0] ers;
    logic         ei;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic [N-1:0] v, input logic h,
                              input logic [N-1:0] er, input logic [N-1:0] ers, input logic ei);
    vec_t t;
    t.rst = r; t.v = v; t.h = h; t.er = er; t.ers = ers; t.ei = ei;
    tbl.push_back(t);
  endfunction

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    halt      = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic step(input int id, input logic [N-1:0] v, input logic h,
                      input logic [N-1:0] er, input logic [N-1:0] ers, input logic ei);
    logic [W-1:0] exp_th, exp_rv;
    logic         exp_sc;
    req_valid = v;
    halt      = h;
    exp_th = (er != 0) ? th[oh2idx(er)] : '0;
    exp_sc = (er != 0) ? sc_v[oh2idx(er)] : 1'b0;
    exp_rv = (ers != 0) ? calc_f(th[oh2idx(ers)], sc_v[oh2idx(ers)]) : '0;
    @(negedge clk);
    chk($sformatf("r%0d req_ready", id),   32'(req_ready),        32'(er));
    chk($sformatf("r%0d calc_enable", id), 32'(calc_enable),      32'(er != 0));
    chk($sformatf("r%0d calc_theta", id),  calc_theta,            exp_th);
    chk($sformatf("r%0d calc_sc", id),     32'(calc_sine_cosine), 32'(exp_sc));
    chk($sformatf("r%0d resp_valid", id),  32'(resp_valid),       32'(ers));
    chk($sformatf("r%0d resp_value", id),  resp_value,            exp_rv);
    chk($sformatf("r%0d idle", id),        32'(idle),             32'(ei));
    chk($sformatf("r%0d issue_count", id), 32'(issue_count),      32'(exp_cnt));
    if (er != 0) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    th[0] = 32'h3F80_0000; th[1] = 32'h4000_0011;
    th[2] = 32'h3F00_0000; th[3] = 32'hC040_0033;
    sc_v  = 4'b1010;
    req_theta       = {th[3], th[2], th[1], th[0]};
    req_sine_cosine = sc_v;
    rst_n = 1'b0; halt = 1'b0; req_valid = '0; exp_cnt = '0;

    // single request from requester 2 at cycle 5
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    for (int k = 1; k < 5; k++) add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0100, 0, 4'b0100, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    // fairness from reset
    add(1, 4'b1111, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b1111, 0, 4'b0010, 4'b0000, 0);
    add(0, 4'b1111, 0, 4'b0100, 4'b0001, 0);
    add(0, 4'b1111, 0, 4'b1000, 4'b0010, 0);
    add(0, 4'b1111, 0, 4'b0001, 4'b0100, 0);
    add(0, 4'b1111, 0, 4'b0010, 4'b1000, 0);
    add(0, 4'b1111, 0, 4'b0100, 4'b0001, 0);
    add(0, 4'b1111, 0, 4'b1000, 4'b0010, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    // pointer carry-over: grant 1, idle, then 0 and 1 together
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0010, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0010, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    // halt drain with requesters 0 and 3 streaming, halt in cycle 10
    for (int k = 0; k < 10; k++)
      add(k == 0, 4'b1001, 0, (k % 2 == 0) ? 4'b0001 : 4'b1000,
          (k < 2) ? 4'b0000 : ((k % 2 == 0) ? 4'b0001 : 4'b1000), 0);
    add(0, 4'b1001, 1, 4'b0000, 4'b0001, 0);
    add(0, 4'b1001, 1, 4'b0000, 4'b1000, 0);
    add(0, 4'b1001, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b1001, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b1001, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b1001, 0, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    // counter wrap: 17 grants on a 4-bit counter
    for (int k = 0; k < 17; k++)
      add(k == 0, 4'b0001, 0, 4'b0001, (k < 2) ? 4'b0000 : 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(i, tbl[i].v, tbl[i].h, tbl[i].er, tbl[i].ers, tbl[i].ei);
      if (i == 19) chk("fairness issue_count", 32'(issue_count), 32'd8);
    end
    chk("wrap issue_count", 32'(issue_count), 32'd1);

    // reset mid-flight: grants in cycles 4 and 5, rst_n pulse inside cycle 5
    do_reset();
    for (int k = 0; k < 4; k++) step(100 + k, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    step(104, 4'b0001, 0, 4'b0001, 4'b0000, 0);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mid pre-reset req_ready", 32'(req_ready), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid req_ready",   32'(req_ready),   32'h0);
    chk("mid calc_enable", 32'(calc_enable), 32'h0);
    chk("mid calc_theta",  calc_theta,       32'h0);
    chk("mid resp_valid",  32'(resp_valid),  32'h0);
    chk("mid resp_value",  resp_value,       32'h0);
    chk("mid idle",        32'(idle),        32'h1);
    chk("mid issue_count", 32'(issue_count), 32'h0);
    req_valid = '0;
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    step(106, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    step(107, 4'b0000, 0, 4'b0000, 4'b0000, 1);
    step(108, 4'b1111, 0, 4'b0001, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
